// File: rtl/adder_vec_checker.sv
// Exhaustive stimulus/response checker for a registered 4-bit adder.
// Sweeps all 512 {C0,A,B} vectors and scores {C4,S} against A+B+C0 after LAT cycles.
module adder_vec_checker #(
  parameter int unsigned LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_in,
  input  logic [3:0] S_in,
  input  logic       C4_in,
  output logic [3:0] A_out,
  output logic [3:0] B_out,
  output logic       C0_out,
  output logic       busy_out,
  output logic       done_out,
  output logic [9:0] pass_cnt_out,
  output logic [9:0] fail_cnt_out,
  output logic [8:0] first_fail_out,
  output logic       err_out
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [8:0] v_q, v_d;
  logic [2:0] drain_q, drain_d;
  logic [9:0] pass_q, pass_d;
  logic [9:0] fail_q, fail_d;
  logic [8:0] ff_q, ff_d;
  logic       err_q, err_d;

  logic [LAT-1:0]      vld_q, vld_d;
  logic [LAT-1:0][4:0] exp_q, exp_d;
  logic [LAT-1:0][8:0] vec_q, vec_d;

  logic       issue;
  logic [4:0] exp_new;

  assign issue   = (state_q == ST_RUN);
  assign exp_new = {1'b0, v_q[7:4]} + {1'b0, v_q[3:0]} + {4'b0, v_q[8]};

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    drain_d = drain_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    ff_d    = ff_q;
    err_d   = err_q;

    vld_d[0] = issue;
    exp_d[0] = exp_new;
    vec_d[0] = v_q;
    for (int unsigned i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      exp_d[i] = exp_q[i-1];
      vec_d[i] = vec_q[i-1];
    end

    if (vld_q[LAT-1]) begin
      if ({C4_in, S_in} == exp_q[LAT-1]) begin
        pass_d = pass_q + 10'd1;
      end else begin
        fail_d = fail_q + 10'd1;
        if (!err_q) begin
          ff_d  = vec_q[LAT-1];
          err_d = 1'b1;
        end
      end
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // The pipe holds no valid entries here, so clearing cannot drop a compare.
        if (start_in) begin
          state_d = ST_RUN;
          v_d     = '0;
          pass_d  = '0;
          fail_d  = '0;
          ff_d    = '0;
          err_d   = 1'b0;
        end
      end
      ST_RUN: begin
        v_d = v_q + 9'd1;
        if (v_q == 9'h1FF) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
      default: begin
        drain_d = drain_q + 3'd1;
        if (drain_q == 3'(LAT - 1)) begin
          state_d = ST_DONE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      drain_q <= '0;
      pass_q  <= '0;
      fail_q  <= '0;
      ff_q    <= '0;
      err_q   <= 1'b0;
      vld_q   <= '0;
      exp_q   <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      drain_q <= drain_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      ff_q    <= ff_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      exp_q   <= exp_d;
      vec_q   <= vec_d;
    end
  end

  assign A_out          = issue ? v_q[7:4] : '0;
  assign B_out          = issue ? v_q[3:0] : '0;
  assign C0_out         = issue ? v_q[8]   : 1'b0;
  assign busy_out       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done_out       = (state_q == ST_DONE);
  assign pass_cnt_out   = pass_q;
  assign fail_cnt_out   = fail_q;
  assign first_fail_out = ff_q;
  assign err_out        = err_q;

endmodule

// File: tb/tb_adder_vec_checker.sv
// Bench for adder_vec_checker: two checker instances (LAT=2, LAT=3) each facing a
// behavioural registered adder with selectable latency and a stuck-bit fault.
module tb_adder_vec_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start = 1'b0;

  logic [3:0] a2, b2, s2, a3, b3, s3;
  logic       c02, c4_2, busy2, done2, err2;
  logic       c03, c4_3, busy3, done3, err3;
  logic [9:0] pass2, fail2, pass3, fail3;
  logic [8:0] ff2, ff3;

  adder_vec_checker #(.LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start_in(start), .S_in(s2), .C4_in(c4_2),
    .A_out(a2), .B_out(b2), .C0_out(c02), .busy_out(busy2), .done_out(done2),
    .pass_cnt_out(pass2), .fail_cnt_out(fail2), .first_fail_out(ff2), .err_out(err2)
  );

  adder_vec_checker #(.LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start_in(start), .S_in(s3), .C4_in(c4_3),
    .A_out(a3), .B_out(b3), .C0_out(c03), .busy_out(busy3), .done_out(done3),
    .pass_cnt_out(pass3), .fail_cnt_out(fail3), .first_fail_out(ff3), .err_out(err3)
  );

  // Registered adder models: output is the sum registered model_lat edges ago.
  logic [4:0]  m2 [8];
  logic [4:0]  m3 [8];
  int unsigned model2_lat   = 2;
  logic        model2_fault = 1'b0;

  always @(posedge clk) begin
    m2[0] <= {1'b0, a2} + {1'b0, b2} + {4'b0, c02};
    m3[0] <= {1'b0, a3} + {1'b0, b3} + {4'b0, c03};
    for (int i = 1; i < 8; i++) begin
      m2[i] <= m2[i-1];
      m3[i] <= m3[i-1];
    end
  end

  always_comb begin
    {c4_2, s2} = m2[model2_lat-1];
    if (model2_fault) s2[0] = 1'b0;
    {c4_3, s3} = m3[2];
  end

  int total = 0;
  int bad   = 0;

  function automatic int unsigned ref_sum(input int unsigned v);
    return ((v >> 4) & 15) + (v & 15) + (v >> 8);
  endfunction

  // Expected sweep result from plain enumeration of what the adder returns per vector.
  function automatic void ref_sweep(input bit fault, input bit late,
                                    output int unsigned p, output int unsigned f,
                                    output int unsigned first);
    int unsigned expv, obs;
    bit seen;
    p = 0; f = 0; first = 0; seen = 0;
    for (int unsigned v = 0; v < 512; v++) begin
      expv = ref_sum(v);
      obs  = late ? ((v == 0) ? 0 : ref_sum(v - 1)) : expv;
      if (fault) obs = obs & ~32'd1;
      if (obs == expv) p++;
      else begin
        f++;
        if (!seen) first = v;
        seen = 1;
      end
    end
  endfunction

  function automatic bit all_zero();
    return ({a2, b2, c02, busy2, done2, pass2, fail2, ff2, err2} == '0) &&
           ({a3, b3, c03, busy3, done3, pass3, fail3, ff3, err3} == '0);
  endfunction

  // Drives one sweep from IDLE/DONE and records observations; no pass/fail judgement here.
  task automatic do_sweep(input int inj1, input int inj2, input int abort_at,
                          output int busy2_n, output int busy3_n,
                          output int done2_at, output int done3_at,
                          output int drive_bad, output bit clr_ok,
                          output bit overlap, output bit timeout);
    int i;
    busy2_n = 0; busy3_n = 0; done2_at = -1; done3_at = -1;
    drive_bad = 0; clr_ok = 0; overlap = 0; timeout = 1;
    @(negedge clk);
    start = 1'b1;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      start = (i == inj1 || i == inj2);
      if (i == 0)
        clr_ok = busy2 && !done2 && pass2 == 0 && fail2 == 0 && ff2 == 0 && !err2 &&
                 busy3 && !done3 && pass3 == 0 && fail3 == 0 && ff3 == 0 && !err3;
      if (i == abort_at) begin
        rst = 1'b1;
        start = 1'b0;
        timeout = 0;
        return;
      end
      if (i < 512) begin
        if ({c02, a2, b2} !== 9'(i) || {c03, a3, b3} !== 9'(i)) drive_bad++;
      end else begin
        if ({c02, a2, b2} !== 9'd0 || {c03, a3, b3} !== 9'd0) drive_bad++;
      end
      if (busy2) busy2_n++;
      if (busy3) busy3_n++;
      if ((busy2 && done2) || (busy3 && done3)) overlap = 1;
      if (done2 && done2_at < 0) done2_at = i;
      if (done3 && done3_at < 0) done3_at = i;
      if (done2 && done3) begin
        timeout = 0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    int zero_bad;
    rst = 1'b1; start = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (!all_zero()) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
    end
    rst = 1'b0; start = 1'b0;
    zero_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!all_zero()) zero_bad++;
    end
    total++;
    if (zero_bad !== 0) begin
      bad++; $display("FAIL idle_outputs: got %0d nonzero cycles, expected 0", zero_bad);
    end
  endtask

  task automatic test_clean(input string name);
    int b2n, b3n, d2, d3, drv; bit clr, ovl, to;
    int unsigned p, f, first;
    ref_sweep(0, 0, p, f, first);
    do_sweep(-1, -1, -1, b2n, b3n, d2, d3, drv, clr, ovl, to);
    total++; if (to !== 0) begin bad++; $display("FAIL %s_timeout: got 1 expected 0", name); end
    total++; if (b2n !== 514) begin bad++; $display("FAIL %s_busy2: got %0d expected 514", name, b2n); end
    total++; if (d2 !== 514) begin bad++; $display("FAIL %s_done2_at: got %0d expected 514", name, d2); end
    total++; if (b3n !== 515) begin bad++; $display("FAIL %s_busy3: got %0d expected 515", name, b3n); end
    total++; if (d3 !== 515) begin bad++; $display("FAIL %s_done3_at: got %0d expected 515", name, d3); end
    total++; if (drv !== 0) begin bad++; $display("FAIL %s_drive: got %0d bad cycles expected 0", name, drv); end
    total++; if (!clr) begin bad++; $display("FAIL %s_start_clear: got 0 expected 1", name); end
    total++; if (ovl !== 0) begin bad++; $display("FAIL %s_busy_done_overlap: got 1 expected 0", name); end
    total++; if (pass2 !== 10'(p)) begin bad++; $display("FAIL %s_pass2: got %0d expected %0d", name, pass2, p); end
    total++; if (fail2 !== 10'(f)) begin bad++; $display("FAIL %s_fail2: got %0d expected %0d", name, fail2, f); end
    total++; if (ff2 !== 9'(first) || err2 !== 1'b0) begin
      bad++; $display("FAIL %s_ff_err2: got ff=%0h err=%0b expected ff=%0h err=0", name, ff2, err2, first);
    end
    total++; if (pass3 !== 10'd512 || fail3 !== 10'd0) begin
      bad++; $display("FAIL %s_dut3: got pass=%0d fail=%0d expected 512/0", name, pass3, fail3);
    end
  endtask

  task automatic test_stuck_bit();
    int b2n, b3n, d2, d3, drv; bit clr, ovl, to;
    int unsigned p, f, first;
    model2_fault = 1'b1;
    ref_sweep(1, 0, p, f, first);
    do_sweep(-1, -1, -1, b2n, b3n, d2, d3, drv, clr, ovl, to);
    model2_fault = 1'b0;
    total++; if (to !== 0) begin bad++; $display("FAIL stuck_timeout: got 1 expected 0"); end
    total++; if (pass2 !== 10'(p) || fail2 !== 10'(f)) begin
      bad++; $display("FAIL stuck_counts: got %0d/%0d expected %0d/%0d", pass2, fail2, p, f);
    end
    total++; if (ff2 !== 9'(first) || err2 !== 1'b1) begin
      bad++; $display("FAIL stuck_first: got ff=%0h err=%0b expected ff=%0h err=1", ff2, err2, first);
    end
    total++; if (pass3 !== 10'd512) begin bad++; $display("FAIL stuck_dut3: got %0d expected 512", pass3); end
  endtask

  task automatic test_latency();
    int b2n, b3n, d2, d3, drv; bit clr, ovl, to;
    int unsigned p, f, first;
    model2_lat = 3;
    ref_sweep(0, 1, p, f, first);
    do_sweep(-1, -1, -1, b2n, b3n, d2, d3, drv, clr, ovl, to);
    total++; if (fail2 == 0 || err2 !== 1'b1) begin
      bad++; $display("FAIL late_detect: got fail=%0d err=%0b expected fail>0 err=1", fail2, err2);
    end
    total++; if (pass2 !== 10'(p) || fail2 !== 10'(f) || ff2 !== 9'(first)) begin
      bad++; $display("FAIL late_counts: got %0d/%0d ff=%0h expected %0d/%0d ff=%0h", pass2, fail2, ff2, p, f, first);
    end
    total++; if (pass3 !== 10'd512 || err3 !== 1'b0) begin
      bad++; $display("FAIL late_lat3: got pass=%0d err=%0b expected 512/0", pass3, err3);
    end
    model2_lat = 2;
  endtask

  task automatic test_ignore_start();
    int b2n, b3n, d2, d3, drv; bit clr, ovl, to;
    int inj2;
    inj2 = 512 + int'($urandom_range(0, 1));
    do_sweep(100, inj2, -1, b2n, b3n, d2, d3, drv, clr, ovl, to);
    total++; if (b2n !== 514 || d2 !== 514) begin
      bad++; $display("FAIL ignore_timing: got busy=%0d done_at=%0d expected 514/514", b2n, d2);
    end
    total++; if (drv !== 0) begin bad++; $display("FAIL ignore_drive: got %0d expected 0", drv); end
    total++; if (pass2 !== 10'd512 || fail2 !== 10'd0 || pass3 !== 10'd512) begin
      bad++; $display("FAIL ignore_counts: got %0d/%0d/%0d expected 512/0/512", pass2, fail2, pass3);
    end
  endtask

  task automatic test_abort();
    int b2n, b3n, d2, d3, drv; bit clr, ovl, to;
    do_sweep(-1, -1, 300, b2n, b3n, d2, d3, drv, clr, ovl, to);
    @(negedge clk);
    total++; if (!all_zero()) begin
      bad++; $display("FAIL abort_reset: got busy=%0b pass=%0d a=%0h expected all 0", busy2, pass2, a2);
    end
    rst = 1'b0;
    repeat (int'($urandom_range(3, 10))) @(negedge clk);
    total++; if (done2 !== 1'b0 || busy2 !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got busy=%0b done=%0b expected 0/0", busy2, done2);
    end
  endtask

  initial begin
    test_reset();
    test_clean("first");
    test_stuck_bit();
    repeat (int'($urandom_range(0, 5))) @(negedge clk);
    test_clean("back_to_back");
    test_latency();
    test_ignore_start();
    test_abort();
    test_clean("after_abort");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
